// File: rtl/fft_pkg.sv
// Shared FFT definitions: default transform geometry, word width and the
// bit-reversal helper used to map butterfly output order to natural order.
package fft_pkg;

    localparam int unsigned FFT_N        = 8;
    localparam int unsigned FFT_BITS     = 3;
    localparam int unsigned FFT_DATA_W   = 32;

    // Widest index the bit-reversal helper supports; callers pass the live
    // width and truncate the result to it.
    localparam int unsigned BITREV_MAX_W = 16;
    localparam int unsigned BITREV_IDX_W = $clog2(BITREV_MAX_W);

    // Reverse the low w bits of x; bits at and above w come back as zero.
    function automatic logic [BITREV_MAX_W-1:0] bitrev(
        input logic [BITREV_MAX_W-1:0] x,
        input int unsigned             w
    );
        logic [BITREV_MAX_W-1:0] r;
        logic [BITREV_IDX_W-1:0] src;
        r = '0;
        for (int unsigned i = 0; i < BITREV_MAX_W; i++) begin
            if (i < w) begin
                src = BITREV_IDX_W'(w - 1 - i);
                r[BITREV_IDX_W'(i)] = x[src];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
//   clk   : clock, all logic on posedge
//   rst   : synchronous active-high reset of the read data register only
//   we    : write enable; waddr/wdata written at the edge
//   re    : read enable; rdata updates one cycle later, otherwise holds
//   raddr : read address
//   rdata : registered read data (cleared by rst, contents are not)
module fft_sdp_ram #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // rdata only moves on a read, so it doubles as the held output word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bitrev_unloader.sv
// FFT output reorder buffer. Words arrive in bit-reversed index order, are
// written at their bit-reversed address, and are streamed out in natural
// order. Two ping-pong banks let one frame fill while the previous drains.
//   clk, rst              : clock and synchronous active-high reset
//   in_valid/in_data      : upstream word (k-th word of a frame = index bitrev(k))
//   in_ready              : write bank has room
//   out_valid/out_data    : natural-order word
//   out_index/out_last    : its index, and high on index N-1
//   out_ready             : downstream accepts
//   frame_done            : one-cycle pulse after the out_last handshake
module bitrev_unloader
    import fft_pkg::*;
#(
    parameter int unsigned N            = FFT_N,
    parameter int unsigned BITS_PER_ROW = FFT_BITS,
    parameter int unsigned DATA_W       = FFT_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic [BITS_PER_ROW-1:0] out_index,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    frame_done
);

    localparam logic [BITS_PER_ROW-1:0] LAST_IDX = BITS_PER_ROW'(N - 1);

    logic [BITS_PER_ROW-1:0] wcnt;
    logic [BITS_PER_ROW-1:0] rcnt;
    logic                    wbank;
    logic                    rbank;
    logic [1:0]              full;
    logic [1:0]              full_next;
    logic                    wr_en;
    logic                    rd_issue;
    logic [BITS_PER_ROW-1:0] waddr_row;

    always_comb begin
        in_ready  = !full[wbank];
        wr_en     = in_valid && in_ready;
        // A new read may issue when the output register is empty or being
        // consumed this cycle.
        rd_issue  = full[rbank] && (!out_valid || out_ready);
        waddr_row = BITS_PER_ROW'(bitrev(BITREV_MAX_W'(wcnt), BITS_PER_ROW));

        // Set and clear always target different banks: a write needs
        // !full on its bank while a read needs full on its bank.
        full_next = full;
        if (wr_en && (wcnt == LAST_IDX)) begin
            full_next[wbank] = 1'b1;
        end
        if (rd_issue && (rcnt == LAST_IDX)) begin
            full_next[rbank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt       <= '0;
            rcnt       <= '0;
            wbank      <= 1'b0;
            rbank      <= 1'b0;
            full       <= '0;
            out_valid  <= 1'b0;
            out_index  <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            full       <= full_next;
            frame_done <= out_valid && out_ready && out_last;

            if (wr_en) begin
                wcnt <= wcnt + BITS_PER_ROW'(1);
                if (wcnt == LAST_IDX) begin
                    wbank <= ~wbank;
                end
            end

            if (rd_issue) begin
                rcnt      <= rcnt + BITS_PER_ROW'(1);
                out_valid <= 1'b1;
                out_index <= rcnt;
                out_last  <= (rcnt == LAST_IDX);
                if (rcnt == LAST_IDX) begin
                    rbank <= ~rbank;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Both banks live in one RAM with the bank bit as address MSB.
    fft_sdp_ram #(
        .DEPTH  (2 * N),
        .ADDR_W (BITS_PER_ROW + 1),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr ({wbank, waddr_row}),
        .wdata (in_data),
        .re    (rd_issue),
        .raddr ({rbank, rcnt}),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_bitrev_unloader.sv
module tb_bitrev_unloader;

    typedef struct {
        logic [31:0] data;
        logic [31:0] idx;
        logic [31:0] last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mon_en = 1'b0;

    // N = 8 instance
    logic        in_valid, in_ready, out_valid, out_last, out_ready, frame_done;
    logic [31:0] in_data, out_data;
    logic [2:0]  out_index;

    // N = 16 instance
    logic        in_valid_b, in_ready_b, out_valid_b, out_last_b, out_ready_b, frame_done_b;
    logic [31:0] in_data_b, out_data_b;
    logic [3:0]  out_index_b;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    exp_t exp_q[$];
    exp_t exp_qb[$];

    always #5 clk = ~clk;

    bitrev_unloader #(.N(8), .BITS_PER_ROW(3), .DATA_W(32)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .frame_done (frame_done)
    );

    bitrev_unloader #(.N(16), .BITS_PER_ROW(4), .DATA_W(32)) dut16 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid_b),
        .in_data    (in_data_b),
        .in_ready   (in_ready_b),
        .out_valid  (out_valid_b),
        .out_data   (out_data_b),
        .out_index  (out_index_b),
        .out_last   (out_last_b),
        .out_ready  (out_ready_b),
        .frame_done (frame_done_b)
    );

    function automatic logic [31:0] rev(input int unsigned x, input int unsigned w);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < w; i++) begin
            if (((x >> i) & 1) != 0) begin
                r = r | (32'd1 << (w - 1 - i));
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic bound_ok(input string tag, input int unsigned used, input int unsigned limit);
        vectors++;
        assert (used < limit) else begin
            miscompares++;
            $error("FAIL %s: observed %0d cycles expected fewer than %0d", tag, used, limit);
        end
    endtask

    // Expected natural-order output of one N=8 frame whose k-th input is base+k.
    task automatic push_exp(input logic [31:0] base);
        exp_t e;
        for (int unsigned i = 0; i < 8; i++) begin
            e.data = base + rev(i, 3);
            e.idx  = i;
            e.last = (i == 7) ? 32'd1 : 32'd0;
            exp_q.push_back(e);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accept edge.
    task automatic push_word(input logic [31:0] d, input bit must_ready);
        int unsigned guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        if (must_ready) check("in_ready_stream", 32'(in_ready), 32'd1);
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        bound_ok("accept_wait", guard, 300);
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input logic [31:0] base, input int unsigned cnt, input bit must_ready);
        for (int unsigned k = 0; k < cnt; k++) begin
            push_word(base + k, must_ready);
        end
    endtask

    task automatic wait_drain(input string tag);
        int unsigned guard;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        bound_ok(tag, guard, 300);
        @(posedge clk);
        #1;
    endtask

    // N=8 output monitor: scoreboard pop on handshake, hold-while-stalled,
    // and frame_done one cycle after the out_last handshake.
    logic        prev_hold = 1'b0;
    logic        exp_fd    = 1'b0;
    logic [31:0] held_d;
    logic [2:0]  held_i;
    logic        held_l;

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (prev_hold) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data",  out_data, held_d);
                check("hold_index", 32'(out_index), 32'(held_i));
                check("hold_last",  32'(out_last), 32'(held_l));
            end
            check("frame_done", 32'(frame_done), 32'(exp_fd));
            if (!rst && out_valid && out_ready) begin
                vectors++;
                assert (exp_q.size() != 0) else begin
                    miscompares++;
                    $error("FAIL out_unexpected: observed word 0x%h index %0d expected no output", out_data, out_index);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_data",  out_data, e.data);
                    check("out_index", 32'(out_index), e.idx);
                    check("out_last",  32'(out_last), e.last);
                end
            end
            prev_hold = !rst && out_valid && !out_ready;
            exp_fd    = !rst && out_valid && out_ready && out_last;
            held_d    = out_data;
            held_i    = out_index;
            held_l    = out_last;
        end
    end

    // N=16 output monitor.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !rst && out_valid_b && out_ready_b) begin
            vectors++;
            assert (exp_qb.size() != 0) else begin
                miscompares++;
                $error("FAIL out16_unexpected: observed word 0x%h index %0d expected no output", out_data_b, out_index_b);
            end
            if (exp_qb.size() != 0) begin
                e = exp_qb.pop_front();
                check("out16_data",  out_data_b, e.data);
                check("out16_index", 32'(out_index_b), e.idx);
                check("out16_last",  32'(out_last_b), e.last);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t        e;
        int unsigned guard;

        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;
        in_valid_b  = 1'b0;
        in_data_b   = '0;
        out_ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        @(negedge clk);
        check("rst_in_ready",   32'(in_ready), 32'd1);
        check("rst_out_valid",  32'(out_valid), 32'd0);
        check("rst_out_data",   out_data, 32'd0);
        check("rst_out_index",  32'(out_index), 32'd0);
        check("rst_out_last",   32'(out_last), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single frame with latency check
        push_exp(32'h00);
        push_words(32'h00, 8, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_t1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_t2_valid", 32'(out_valid), 32'd1);
        check("lat_t2_data",  out_data, 32'h00);
        @(posedge clk);
        #1;
        wait_drain("drain_single");

        // Three back-to-back frames; in_ready must stay high throughout
        push_exp(32'h00);
        push_exp(32'h10);
        push_exp(32'h20);
        push_words(32'h00, 8, 1'b1);
        push_words(32'h10, 8, 1'b1);
        push_words(32'h20, 8, 1'b1);
        in_valid = 1'b0;
        wait_drain("drain_b2b");

        // Backpressure: two frames fill both banks, third stalls
        out_ready = 1'b0;
        push_exp(32'h40);
        push_exp(32'h50);
        push_exp(32'h60);
        push_words(32'h40, 8, 1'b1);
        push_words(32'h50, 8, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'h60;
        repeat (4) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        check("bp_out_valid_held", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push_words(32'h60, 8, 1'b0);
        in_valid = 1'b0;
        wait_drain("drain_bp");

        // Output stall hold with out_ready toggling every cycle
        push_exp(32'h70);
        fork
            begin
                push_words(32'h70, 8, 1'b1);
                in_valid = 1'b0;
            end
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1;
                    out_ready = ~out_ready;
                end
            end
        join
        out_ready = 1'b1;
        wait_drain("drain_toggle");

        // Reset mid-operation: one full frame held at the output, five words
        // of the next frame partly written
        out_ready = 1'b0;
        push_words(32'h80, 8, 1'b1);
        push_words(32'h90, 5, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_rst_in_ready",   32'(in_ready), 32'd1);
        check("mid_rst_out_valid",  32'(out_valid), 32'd0);
        check("mid_rst_out_data",   out_data, 32'd0);
        check("mid_rst_out_index",  32'(out_index), 32'd0);
        check("mid_rst_out_last",   32'(out_last), 32'd0);
        check("mid_rst_frame_done", 32'(frame_done), 32'd0);
        check("mid_rst_full",       32'(dut8.full), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        push_exp(32'h30);
        push_words(32'h30, 8, 1'b1);
        in_valid = 1'b0;
        wait_drain("drain_post_rst");

        // N = 16 instance: index i must carry input bitrev4(i)
        for (int unsigned i = 0; i < 16; i++) begin
            e.data = 32'h100 + rev(i, 4);
            e.idx  = i;
            e.last = (i == 15) ? 32'd1 : 32'd0;
            exp_qb.push_back(e);
        end
        in_valid_b = 1'b1;
        for (int unsigned k = 0; k < 16; k++) begin
            in_data_b = 32'h100 + k;
            @(negedge clk);
            check("in16_ready", 32'(in_ready_b), 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid_b = 1'b0;
        guard = 0;
        while ((exp_qb.size() != 0 || out_valid_b) && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        bound_ok("drain_n16", guard, 300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bitrev_unloader.md
Name: bitrev_unloader

Overview:
- Output-side reorder buffer for the FFT. The butterfly datapath delivers results in bit-reversed index order; this block writes each result at its bit-reversed address and streams frames out in natural index order.
- Two-bank ping-pong store of N words each. One bank fills while the other drains, so frame k+1 can be accepted while frame k is unloaded.
- Sits between the FFT stage engine (upstream, valid/ready) and the result sink (downstream, valid/ready).

Parameters:
- N, 8, transform length; power of two, N >= 4.
- BITS_PER_ROW, 3, log2(N); width of an address within a bank.
- DATA_W, 32, width of one complex result word (packed re/im, opaque to this block).

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  upstream word present.
- in_data  input  DATA_W  result word; k-th accepted word of a frame has bit-reversed index k.
- in_ready  output  1  block can accept in_data this cycle.
- out_valid  output  1  out_data/out_index/out_last are valid.
- out_data  output  DATA_W  result word, natural order.
- out_index  output  BITS_PER_ROW  natural index of out_data (0..N-1).
- out_last  output  1  high with index N-1.
- out_ready  input  1  downstream accepts this cycle.
- frame_done  output  1  one-cycle pulse after the handshake of the out_last word.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, out_index=0, out_last=0, frame_done=0. Internal reset values: wcnt=0, rcnt=0, wbank=0, rbank=0, full=2'b00. RAM contents are not reset.
- rst wins over every other event in a cycle. Reset mid-frame discards both banks and any partial frame; a held out word is dropped.
- Write side:
  - in_ready = !full[wbank] (combinational from registers).
  - Accept when in_valid && in_ready: bank[wbank][bitrev(wcnt)] <= in_data, then wcnt++.
  - On the accept with wcnt==N-1: set full[wbank], toggle wbank, wcnt wraps to 0.
- Read side (synchronous-read RAM, one-cycle latency):
  - Issue a read when full[rbank] && (!out_valid || out_ready). Read address is rcnt.
  - The cycle after an issue: out_valid=1, out_data=RAM word, out_index=rcnt, out_last=(rcnt==N-1).
  - If out_valid && out_ready and no read was issued, out_valid drops to 0 the next cycle.
  - While out_valid && !out_ready, out_data, out_index and out_last hold stable.
  - When the read with rcnt==N-1 is issued: clear full[rbank], toggle rbank, rcnt wraps to 0.
  - frame_done pulses for one cycle in the cycle after out_last is handshaken.
- Throughput: one word per cycle on both sides when unstalled.
- Latency: the last input is accepted in cycle t; full is set at the t edge; the first read issues in t+1; out_valid is high in t+2.
- Simultaneous events:
  - A set of full on one bank and a clear on the other bank in the same cycle are independent and both take effect.
  - A set and a clear on the same bank cannot occur, because a write requires !full on that bank.
  - In the cycle a bank is released, a write may target it only from the next cycle, since in_ready comes from registers.
- Both banks full: in_ready=0, and upstream stalls without loss.
- bitrev(x) reverses the BITS_PER_ROW bits of x. All counters are BITS_PER_ROW wide and wrap naturally.
- Out-of-frame protocol does not exist: every frame is exactly N words, with no in_last input.

Decomposition:
- Shared package fft_pkg:
  - bitrev function, parameterised by width.
  - N/BITS_PER_ROW defaults.
  - DATA_W default.
- One natural sub-module, fft_sdp_ram:
  - Simple dual-port, one write port and one synchronous read port, depth N, width DATA_W.
  - Instantiated twice, or once at depth 2N with the bank bit as the address MSB.
- The counter/bank-flag control stays in bitrev_unloader.

Test Plan:
- Single frame, N=8, out_ready=1: input words 0x00..0x07 in order. Output must be 0x00,0x04,0x02,0x06,0x01,0x05,0x03,0x07 with out_index 0..7, out_last on the 8th word, and frame_done one cycle later. The first out_valid comes 2 cycles after the 8th accept.
- Back-to-back frames: three frames streamed continuously, inputs 0x00..0x07, 0x10..0x17, 0x20..0x27, out_ready=1. in_ready must never drop. The outputs are continuous, and each frame has the bit-reversed pattern with its own offset.
- Backpressure: out_ready=0 while 3 frames are offered. The first two frames are accepted, then in_ready=0 for the third. Raising out_ready must deliver all 24 words in order, with the third frame accepted after bank release.
- Output stall hold: toggle out_ready every cycle. out_data, out_index and out_last stay stable while out_valid && !out_ready. There must be no duplicated and no skipped indices.
- Reset mid-operation: assert rst after 5 input words and while out_valid is high. The next cycle shows the reset values and full=0. A fresh frame 0x30..0x37 then produces the clean pattern 0x30,0x34,...,0x37.
- Parameter sweep: N=16 (BITS_PER_ROW=4) with input k=0..15. Output index i must carry word bitrev4(i), e.g. index 1 -> input 8 and index 3 -> input 12.
